// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decoder / pipeline-register side signals of the ID hazard control unit
// master = decoder and pipeline datapath, slave = pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             use_rs;
  logic             use_rt;
  logic [4:0]       ern;
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       mrn;
  logic             mwreg;
  logic             mm2reg;
  logic             id_is_mdu;
  logic             id_uses_hilo;
  logic             br_taken;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             wpcir;
  logic             if_flush;
  logic             id_bubble;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs, rt, use_rs, use_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
           id_is_mdu, id_uses_hilo, br_taken,
    input  fwda, fwdb, wpcir, if_flush, id_bubble, mdu_busy, mdu_done,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
           id_is_mdu, id_uses_hilo, br_taken,
    output fwda, fwdb, wpcir, if_flush, id_bubble, mdu_busy, mdu_done,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-stage hazard control: forwarding, load-use/MDU stalls, flush, counters
// Hazard outputs are combinational; the MDU tracker and event counters are registered.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             load_use;
  logic             mdu_hold;
  logic             stall;
  logic             dispatch;

  // EX result beats MEM; a load still in EX has no data yet and is left to load_use.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ern_i,
    input logic       ewreg_i,
    input logic       em2reg_i,
    input logic [4:0] mrn_i,
    input logic       mwreg_i,
    input logic       mm2reg_i
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ewreg_i && (ern_i != 5'd0) && (ern_i == src) && !em2reg_i)
      sel = 2'b01;
    else if (mwreg_i && (mrn_i != 5'd0) && (mrn_i == src) && mm2reg_i)
      sel = 2'b11;
    else if (mwreg_i && (mrn_i != 5'd0) && (mrn_i == src))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    bus.fwda = fwd_sel(bus.rs, bus.ern, bus.ewreg, bus.em2reg, bus.mrn, bus.mwreg, bus.mm2reg);
    bus.fwdb = fwd_sel(bus.rt, bus.ern, bus.ewreg, bus.em2reg, bus.mrn, bus.mwreg, bus.mm2reg);
  end

  assign load_use = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
                    ((bus.use_rs && (bus.ern == bus.rs)) || (bus.use_rt && (bus.ern == bus.rt)));
  assign mdu_hold = (state == S_BUSY) && (bus.id_is_mdu || bus.id_uses_hilo);
  assign stall    = load_use || mdu_hold;
  assign dispatch = bus.id_is_mdu && !stall;

  assign bus.wpcir     = !stall;
  assign bus.id_bubble = stall;
  assign bus.if_flush  = bus.br_taken && !stall;
  assign bus.mdu_busy  = (state == S_BUSY);
  assign bus.mdu_done  = (state == S_DONE);
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DONE leaves hilo readers free, so a new MDU op can dispatch straight out of it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (dispatch) begin
          state_nxt = S_BUSY;
          cnt_nxt   = LAT_M1;
        end
      end
      S_BUSY: begin
        if (cnt == 4'd0)
          state_nxt = S_DONE;
        else
          cnt_nxt = cnt - 4'd1;
      end
      S_DONE: begin
        if (dispatch) begin
          state_nxt = S_BUSY;
          cnt_nxt   = LAT_M1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!bus.wpcir && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (bus.if_flush && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;

  typedef struct {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             wp;
    logic             fl;
    logic             bub;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t me;
  logic [CNT_W-1:0] m_sc;
  logic [CNT_W-1:0] m_fc;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("fwda",      16'(bus.fwda),      16'(me.fa));
      chk("fwdb",      16'(bus.fwdb),      16'(me.fb));
      chk("wpcir",     16'(bus.wpcir),     16'(me.wp));
      chk("if_flush",  16'(bus.if_flush),  16'(me.fl));
      chk("id_bubble", 16'(bus.id_bubble), 16'(me.bub));
      chk("mdu_busy",  16'(bus.mdu_busy),  16'(me.busy));
      chk("mdu_done",  16'(bus.mdu_done),  16'(me.done));
      chk("stall_cnt", 16'(bus.stall_cnt), 16'(me.sc));
      chk("flush_cnt", 16'(bus.flush_cnt), 16'(me.fc));
    end
  end

  task automatic clr();
    bus.rs = 5'd0; bus.rt = 5'd0; bus.use_rs = 1'b0; bus.use_rt = 1'b0;
    bus.ern = 5'd0; bus.ewreg = 1'b0; bus.em2reg = 1'b0;
    bus.mrn = 5'd0; bus.mwreg = 1'b0; bus.mm2reg = 1'b0;
    bus.id_is_mdu = 1'b0; bus.id_uses_hilo = 1'b0; bus.br_taken = 1'b0;
  endtask

  // Queue this cycle's expectation, advance the counter model, move to the next cycle.
  task automatic cyc(input logic [1:0] fa, input logic [1:0] fb, input logic wp,
                     input logic fl, input logic bub, input logic busy, input logic done);
    exp_t e;
    e.fa = fa; e.fb = fb; e.wp = wp; e.fl = fl; e.bub = bub;
    e.busy = busy; e.done = done; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    if (reset) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (!wp && (m_sc != '1)) m_sc = m_sc + 1'b1;
      if (fl && (m_fc != '1)) m_fc = m_fc + 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr();
    m_sc = '0;
    m_fc = '0;
    repeat (2) @(posedge clock);
    #1;

    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);

    bus.ewreg = 1; bus.ern = 5; bus.rs = 5; bus.rt = 5; bus.mwreg = 1; bus.mrn = 5;
    cyc(2'b01, 2'b01, 1, 0, 0, 0, 0);
    bus.ewreg = 0;
    cyc(2'b10, 2'b10, 1, 0, 0, 0, 0);
    bus.mm2reg = 1;
    cyc(2'b11, 2'b11, 1, 0, 0, 0, 0);
    bus.ewreg = 1; bus.em2reg = 1; bus.mm2reg = 0;
    cyc(2'b10, 2'b10, 1, 0, 0, 0, 0);
    bus.ern = 0; bus.mrn = 0; bus.rs = 0; bus.rt = 0; bus.em2reg = 0;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    bus.rs = 5; bus.rt = 6; bus.ern = 5; bus.mrn = 6; bus.mm2reg = 1;
    cyc(2'b01, 2'b11, 1, 0, 0, 0, 0);

    clr();
    bus.ewreg = 1; bus.em2reg = 1; bus.ern = 7; bus.rt = 7; bus.use_rt = 1;
    cyc(2'b00, 2'b00, 0, 0, 1, 0, 0);
    bus.use_rt = 0;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    bus.rs = 7; bus.use_rs = 1; bus.rt = 0;
    cyc(2'b00, 2'b00, 0, 0, 1, 0, 0);
    bus.ern = 0; bus.rs = 0;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);

    clr();
    bus.id_is_mdu = 1; bus.id_uses_hilo = 1;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    bus.id_is_mdu = 0;
    repeat (4) cyc(2'b00, 2'b00, 0, 0, 1, 1, 0);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 1);
    clr();
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);

    bus.id_is_mdu = 1;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    bus.id_is_mdu = 0;
    repeat (2) cyc(2'b00, 2'b00, 1, 0, 0, 1, 0);
    bus.id_is_mdu = 1;
    repeat (2) cyc(2'b00, 2'b00, 0, 0, 1, 1, 0);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 1);
    bus.id_is_mdu = 0;
    repeat (4) cyc(2'b00, 2'b00, 1, 0, 0, 1, 0);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 1);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);

    clr();
    bus.br_taken = 1;
    cyc(2'b00, 2'b00, 1, 1, 0, 0, 0);
    bus.ewreg = 1; bus.em2reg = 1; bus.ern = 7; bus.rs = 7; bus.use_rs = 1;
    cyc(2'b00, 2'b00, 0, 0, 1, 0, 0);
    clr();
    bus.br_taken = 1;
    cyc(2'b00, 2'b00, 1, 1, 0, 0, 0);
    clr();

    bus.id_is_mdu = 1;
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    bus.id_is_mdu = 0;
    cyc(2'b00, 2'b00, 1, 0, 0, 1, 0);
    reset = 1'b1;
    cyc(2'b00, 2'b00, 1, 0, 0, 1, 0);
    reset = 1'b0;
    repeat (6) cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);

    bus.ewreg = 1; bus.em2reg = 1; bus.ern = 7; bus.rt = 7; bus.use_rt = 1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++)
      cyc(2'b00, 2'b00, 0, 0, 1, 0, 0);
    clr();
    bus.br_taken = 1;
    cyc(2'b00, 2'b00, 1, 1, 0, 0, 0);
    clr();
    cyc(2'b00, 2'b00, 1, 0, 0, 0, 0);
    chk("stall_model_saturated", 16'(m_sc), 16'((1 << CNT_W) - 1));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- ID-stage pipeline control unit.
- Drives the IF/ID register's write-enable (wpcir) and flush (if_flush), the ID/EX bubble, and the ID-stage forwarding selects.
- Tracks an in-flight multi-cycle multiply/divide (MDU) operation with a small FSM, and keeps saturating stall/flush event counters.
- Sits between the decoder and the IF/ID / ID/EX pipeline registers.

Parameters:
- MDU_LAT, 4, EX cycles an MDU op occupies after dispatch (legal range 2..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rs  in  5  ID source register A.
- rt  in  5  ID source register B.
- use_rs  in  1  ID instruction reads rs.
- use_rt  in  1  ID instruction reads rt.
- ern  in  5  EX destination register.
- ewreg  in  1  EX writes register file.
- em2reg  in  1  EX instruction is a load.
- mrn  in  5  MEM destination register.
- mwreg  in  1  MEM writes register file.
- mm2reg  in  1  MEM instruction is a load.
- id_is_mdu  in  1  ID instruction is mult/div.
- id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo).
- br_taken  in  1  ID branch/jump resolved taken.
- fwda  out  2  forward select for rs: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data.
- fwdb  out  2  forward select for rt, same encoding.
- wpcir  out  1  1 = PC and IF/ID may update; 0 = hold.
- if_flush  out  1  1 = zero IF/ID instruction next edge.
- id_bubble  out  1  1 = ID/EX loads a NOP next edge.
- mdu_busy  out  1  MDU FSM in BUSY.
- mdu_done  out  1  one-cycle pulse, MDU result valid in HI/LO.
- stall_cnt  out  CNT_W  cycles with wpcir=0, saturating.
- flush_cnt  out  CNT_W  cycles with if_flush=1, saturating.

Behaviour:
- Forwarding (combinational), evaluated identically for rs→fwda and rt→fwdb:
  - 01 if ewreg & ern!=0 & ern==src & !em2reg.
  - else 11 if mwreg & mrn!=0 & mrn==src & mm2reg.
  - else 10 if mwreg & mrn!=0 & mrn==src.
  - else 00.
  - EX beats MEM. Register 0 is never forwarded.
- load_use = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- mdu_hold = mdu_busy & (id_is_mdu | id_uses_hilo).
- stall = load_use | mdu_hold.
- Outputs:
  - wpcir = !stall.
  - id_bubble = stall.
  - if_flush = br_taken & !stall. Flush never coincides with a hold; a branch waiting on operands flushes in the cycle it is finally dispatched.
- MDU FSM, states IDLE, BUSY, DONE, 4-bit down-counter cnt:
  - IDLE: id_is_mdu & !stall → BUSY, cnt=MDU_LAT-1.
  - BUSY: cnt decrements each cycle; on cnt==0 → DONE.
  - DONE: mdu_done=1 for one cycle.
    - If id_is_mdu & !stall in the same cycle → BUSY, cnt=MDU_LAT-1 (back-to-back).
    - Otherwise → IDLE.
  - mdu_busy=1 only in BUSY. In DONE, hilo readers are not held.
- Counters: on each edge, stall_cnt += (wpcir==0) and flush_cnt += if_flush. Both saturate at all-ones; no wrap.
- Reset (synchronous, active-high), also when asserted mid-operation:
  - FSM→IDLE, cnt=0, both counters=0, mdu_busy=0, mdu_done=0.
  - Combinational outputs follow their inputs; with all-zero inputs, wpcir=1 and every other output is 0.
  - An in-flight MDU op is abandoned.
- Latency: all hazard outputs are combinational, same cycle as inputs. FSM and counters update on the next rising edge.

Test Plan:
- Forwarding: ewreg=1, em2reg=0, ern=5, rs=5, rt=5, plus mwreg=1, mrn=5 → fwda=fwdb=01. Then ewreg=0 → 10; then mm2reg=1 → 11. Repeat with ern=mrn=rs=0 → 00.
- Load-use: em2reg=ewreg=1, ern=7, rt=7, use_rt=1 for one cycle → wpcir=0 and id_bubble=1 that cycle, stall_cnt increments by 1. Same with use_rt=0 → no stall.
- MDU, MDU_LAT=4: pulse id_is_mdu at cycle 0 → mdu_busy=1 for cycles 1–4, mdu_done=1 at cycle 5. id_uses_hilo held high throughout → wpcir=0 for cycles 1–4, 1 at cycle 5, stall_cnt=4.
- Back-to-back MDU: id_is_mdu asserted during the DONE cycle → next cycle BUSY with a fresh count. id_is_mdu asserted during BUSY → held until DONE.
- Branch: br_taken=1 with no hazard → if_flush=1, flush_cnt+1. br_taken=1 together with load_use → if_flush=0 and wpcir=0; next cycle, with no hazard → if_flush=1.
- Reset mid-BUSY (cycle 2 of 4) → next edge mdu_busy=0, no mdu_done pulse afterward, counters=0. Force 2^CNT_W+3 stall cycles → stall_cnt stays at all-ones.
